// File: rtl/stream_clear_seq.sv
// stream_clear_seq: 2-entry stream FIFO with a local flush and clear handshake
// towards a clearable CDC source side.
module stream_clear_seq #(
   parameter type         T         = logic,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_req_i,
   input  T                     in_data_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output T                     out_data_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 cdc_clear_o,
   input  logic                 cdc_clear_pending_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 timeout_o,
   output logic [CNT_WIDTH-1:0] flush_cnt_o
);
   typedef enum logic [2:0] {IDLE, FLUSH, CLEAR, WAIT_HI, WAIT_LO, DONE} state_e;
   localparam int unsigned TW = $clog2(TIMEOUT);
   state_e               state_q;
   T                     mem_q [2];
   logic                 rd_ptr_q, wr_ptr_q, en_q;
   logic [1:0]           cnt_q;
   logic [TW-1:0]        tmo_cnt_q;
   logic [CNT_WIDTH:0]   fc_sum;
   logic                 stall, push, pop;
   // en_q keeps in_ready_o low while reset is held and until the first clock after it
   assign stall       = state_q != IDLE || cdc_clear_pending_i || !en_q;
   assign in_ready_o  = !stall && cnt_q != 2'd2;
   assign out_valid_o = !stall && cnt_q != 2'd0;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;
   assign out_data_o  = mem_q[rd_ptr_q];
   assign cdc_clear_o = state_q == CLEAR;
   assign busy_o      = state_q != IDLE;
   assign done_o      = state_q == DONE;
   assign fc_sum      = {1'b0, flush_cnt_o} + (CNT_WIDTH+1)'(cnt_q);
   always_ff @(posedge clk_i)
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q     <= IDLE;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         en_q        <= 1'b0;
         cnt_q       <= 2'd0;
         tmo_cnt_q   <= '0;
         timeout_o   <= 1'b0;
         flush_cnt_o <= '0;
      end else begin
         en_q <= 1'b1;
         if (state_q == FLUSH) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= wr_ptr_q;
         end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
         end
         case (state_q)
            IDLE: if (clear_req_i) begin
               state_q   <= FLUSH;
               timeout_o <= 1'b0;
            end
            FLUSH: begin
               flush_cnt_o <= fc_sum[CNT_WIDTH] ? '1 : fc_sum[CNT_WIDTH-1:0];
               state_q     <= CLEAR;
            end
            CLEAR: begin
               tmo_cnt_q <= '0;
               state_q   <= WAIT_HI;
            end
            WAIT_HI:
               if (cdc_clear_pending_i) state_q <= WAIT_LO;
               else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                  timeout_o <= 1'b1;
                  state_q   <= DONE;
               end else tmo_cnt_q <= tmo_cnt_q + 1'b1;
            WAIT_LO: if (!cdc_clear_pending_i) state_q <= DONE;
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
endmodule

// File: doc/stream_clear_seq.md
STREAM_CLEAR_SEQ -- requirements
Module: stream_clear_seq

Interface
REQ-001 SHALL have parameter T, default logic, meaning the payload type.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the cycles to wait for clear_pending to rise; legal values are 2 to 65535.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, meaning the width of the flush counter.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 SHALL have port clear_req_i, input, 1 bit: the request to start a clear sequence.
REQ-007 SHALL have port in_data_i, input, T: the upstream payload.
REQ-008 SHALL have port in_valid_i, input, 1 bit, and port in_ready_o, output, 1 bit: the upstream handshake.
REQ-009 SHALL have port out_data_o, output, T: the payload sent to the clearable CDC source side.
REQ-010 SHALL have port out_valid_o, output, 1 bit, and port out_ready_i, input, 1 bit: the downstream handshake.
REQ-011 SHALL have port cdc_clear_o, output, 1 bit: the synchronous clear sent to the CDC source side.
REQ-012 SHALL have port cdc_clear_pending_i, input, 1 bit: the clear-pending status from the CDC source side.
REQ-013 SHALL have port busy_o, output, 1 bit: high while a clear sequence is in progress.
REQ-014 SHALL have port done_o, output, 1 bit: a one-cycle pulse when a sequence completes.
REQ-015 SHALL have port timeout_o, output, 1 bit: a sticky flag set when the last sequence timed out.
REQ-016 SHALL have port flush_cnt_o, output, CNT_WIDTH bits: the saturating count of discarded items.

Function
REQ-017 SHALL contain a 2-entry FIFO between the in and out ports; out_data_o SHALL be the head entry.
REQ-018 SHALL drive in_ready_o = (occupancy<2) & state==IDLE & !cdc_clear_pending_i.
REQ-019 SHALL drive out_valid_o = (occupancy>0) & state==IDLE & !cdc_clear_pending_i.
REQ-020 SHALL present an item accepted in cycle t on out_valid_o no earlier than cycle t+1; there is no combinational in-to-out path.
REQ-021 SHALL leave occupancy unchanged on a simultaneous push and pop, and SHALL preserve FIFO order.
REQ-022 SHALL implement the FSM IDLE->FLUSH->CLEAR->WAIT_HI->WAIT_LO->DONE->IDLE, with each transition registered.
REQ-023 IDLE: clear_req_i=1 SHALL move to FLUSH; handshakes in that same cycle SHALL complete normally.
REQ-024 FLUSH (1 cycle): SHALL empty the FIFO and add the occupancy (0-2) to flush_cnt_o, saturating at all-ones.
REQ-025 CLEAR (1 cycle): SHALL assert cdc_clear_o=1, with out_valid_o guaranteed 0.
REQ-026 WAIT_HI: SHALL move to WAIT_LO when cdc_clear_pending_i=1; otherwise it counts cycles and, on the TIMEOUT-th cycle, SHALL set timeout_o and move to DONE.
REQ-027 WAIT_LO: SHALL move to DONE when cdc_clear_pending_i=0, with no timeout.
REQ-028 DONE (1 cycle): SHALL assert done_o=1, then return to IDLE.
REQ-029 busy_o SHALL be 1 in every state except IDLE.
REQ-030 clear_req_i SHALL be ignored outside IDLE.
REQ-031 timeout_o SHALL clear on entry to FLUSH.
REQ-032 A remote-initiated clear (cdc_clear_pending_i=1 in IDLE) SHALL stall both handshakes but SHALL NOT flush the FIFO.
REQ-033 cdc_clear_o SHALL never be asserted outside CLEAR.

Reset
REQ-034 rst_ni=0 SHALL asynchronously force: state=IDLE, FIFO empty, in_ready_o=0 during reset, out_valid_o=0, cdc_clear_o=0, busy_o=0, done_o=0, timeout_o=0, flush_cnt_o=0.
REQ-035 Reset asserted mid-sequence SHALL abort the sequence without a done_o pulse.
REQ-036 The FIFO data storage SHALL NOT require reset.

Verification
REQ-037 Streaming: push 0x11, 0x22, 0x33 with out_ready_i=1 -> out order 0x11, 0x22, 0x33; first out_valid_o one cycle after the first accept.
REQ-038 Full: out_ready_i=0, push 3 items -> in_ready_o=0 after 2 accepts; occupancy 2.
REQ-039 Clear with 2 buffered: pulse clear_req_i; pending rises 3 cycles after CLEAR and falls 5 cycles later -> flush_cnt_o=2, one-cycle cdc_clear_o, done_o pulse, busy_o low afterwards.
REQ-040 Timeout: TIMEOUT=4, pending held 0 -> timeout_o=1 and done_o after 4 WAIT_HI cycles; the next clear_req_i clears timeout_o.
REQ-041 Remote clear: pending=1 in IDLE with 1 item buffered -> out_valid_o=0 and in_ready_o=0; item delivered after pending falls; flush_cnt_o unchanged.
REQ-042 Reset during WAIT_LO -> all outputs reach reset values, with no done_o pulse.
